// File: rtl/id_decode_stage.sv
// MIPS-style decode stage: control decoder, 32x32 register file with write-through
// bypass, and the ID/EX pipeline register. Optional macro ID_FLUSH_EN adds a flush input.
module id_decode_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic [31:0] in_new_pc_value,
    input  logic [4:0]  write_register,
    input  logic [31:0] write_data,
    input  logic        in_RegWrite,
    input  logic [31:0] register_input,
`ifdef ID_FLUSH_EN
    input  logic        flush,
`endif
    output logic [31:0] debug_data,
    output logic [4:0]  instr_bits_15_11,
    output logic [4:0]  instr_bits_20_16,
    output logic [31:0] extended_bits,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic [31:0] new_pc_value,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        ALUSrc,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        MemToReg,
    output logic        Branch,
    output logic [1:0]  load_mode,
    output logic [2:0]  ALUOp
);

    logic [31:0] regs [32];
    logic [4:0]  rs_addr, rt_addr, dbg_addr;
    logic [31:0] rs_val, rt_val;
    logic        wr_active;
    logic        kill;
    logic        unused_bits;

    logic        c_regdst, c_regwrite, c_alusrc, c_memwrite, c_memread, c_memtoreg, c_branch;
    logic [1:0]  c_load_mode;
    logic [2:0]  c_aluop;

    assign rs_addr     = instruction[25:21];
    assign rt_addr     = instruction[20:16];
    assign dbg_addr    = register_input[4:0];
    assign unused_bits = ^register_input[31:5];
    assign wr_active   = in_RegWrite && (write_register != 5'd0);

`ifdef ID_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_active) begin
            regs[write_register] <= write_data;
        end
    end

    // A write landing this cycle is visible to every read port immediately.
    assign rs_val     = (rs_addr == 5'd0) ? '0 :
                        (wr_active && write_register == rs_addr) ? write_data : regs[rs_addr];
    assign rt_val     = (rt_addr == 5'd0) ? '0 :
                        (wr_active && write_register == rt_addr) ? write_data : regs[rt_addr];
    assign debug_data = (dbg_addr == 5'd0) ? '0 :
                        (wr_active && write_register == dbg_addr) ? write_data : regs[dbg_addr];

    always_comb begin
        c_regdst    = 1'b0;
        c_regwrite  = 1'b0;
        c_alusrc    = 1'b0;
        c_memwrite  = 1'b0;
        c_memread   = 1'b0;
        c_memtoreg  = 1'b0;
        c_branch    = 1'b0;
        c_load_mode = 2'b00;
        c_aluop     = 3'b000;
        unique case (instruction[31:26])
            6'b000000: begin
                c_regdst   = 1'b1;
                c_regwrite = 1'b1;
                c_aluop    = 3'b010;
            end
            6'b100011, 6'b100001, 6'b100000, 6'b100100: begin
                c_alusrc   = 1'b1;
                c_memread  = 1'b1;
                c_memtoreg = 1'b1;
                c_regwrite = 1'b1;
                case (instruction[31:26])
                    6'b100001: c_load_mode = 2'b01;
                    6'b100000: c_load_mode = 2'b10;
                    6'b100100: c_load_mode = 2'b11;
                    default:   c_load_mode = 2'b00;
                endcase
            end
            6'b101011: begin
                c_alusrc   = 1'b1;
                c_memwrite = 1'b1;
            end
            6'b000100: begin
                c_branch = 1'b1;
                c_aluop  = 3'b001;
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                c_alusrc   = 1'b1;
                c_regwrite = 1'b1;
                case (instruction[31:26])
                    6'b001100: c_aluop = 3'b011;
                    6'b001101: c_aluop = 3'b100;
                    6'b001010: c_aluop = 3'b101;
                    default:   c_aluop = 3'b000;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_bits_15_11 <= '0;
            instr_bits_20_16 <= '0;
            extended_bits    <= '0;
            read_data1       <= '0;
            read_data2       <= '0;
            new_pc_value     <= '0;
            RegDst           <= 1'b0;
            RegWrite         <= 1'b0;
            ALUSrc           <= 1'b0;
            MemWrite         <= 1'b0;
            MemRead          <= 1'b0;
            MemToReg         <= 1'b0;
            Branch           <= 1'b0;
            load_mode        <= 2'b00;
            ALUOp            <= 3'b000;
        end else begin
            instr_bits_15_11 <= instruction[15:11];
            instr_bits_20_16 <= instruction[20:16];
            extended_bits    <= {{16{instruction[15]}}, instruction[15:0]};
            read_data1       <= rs_val;
            read_data2       <= rt_val;
            new_pc_value     <= in_new_pc_value;
            RegDst           <= c_regdst;
            RegWrite         <= c_regwrite & ~kill;
            ALUSrc           <= c_alusrc;
            MemWrite         <= c_memwrite & ~kill;
            MemRead          <= c_memread & ~kill;
            MemToReg         <= c_memtoreg & ~kill;
            Branch           <= c_branch & ~kill;
            load_mode        <= c_load_mode;
            ALUOp            <= c_aluop;
        end
    end

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: vector table plus reset, latency and flush sequences.
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction, in_new_pc_value, write_data, register_input;
    logic [4:0]  write_register;
    logic        in_RegWrite;
`ifdef ID_FLUSH_EN
    logic        flush;
`endif
    logic [31:0] debug_data, extended_bits, read_data1, read_data2, new_pc_value;
    logic [4:0]  instr_bits_15_11, instr_bits_20_16;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch;
    logic [1:0]  load_mode;
    logic [2:0]  ALUOp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .in_new_pc_value(in_new_pc_value),
        .write_register(write_register), .write_data(write_data), .in_RegWrite(in_RegWrite),
        .register_input(register_input),
`ifdef ID_FLUSH_EN
        .flush(flush),
`endif
        .debug_data(debug_data), .instr_bits_15_11(instr_bits_15_11),
        .instr_bits_20_16(instr_bits_20_16), .extended_bits(extended_bits),
        .read_data1(read_data1), .read_data2(read_data2), .new_pc_value(new_pc_value),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemToReg(MemToReg), .Branch(Branch), .load_mode(load_mode),
        .ALUOp(ALUOp)
    );

    // ctrl packing: {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,Branch,load_mode[1:0],ALUOp[2:0]}
    localparam logic [11:0] C_R    = 12'b1100_0000_0010;
    localparam logic [11:0] C_LW   = 12'b0110_1100_0000;
    localparam logic [11:0] C_LH   = 12'b0110_1100_1000;
    localparam logic [11:0] C_LB   = 12'b0110_1101_0000;
    localparam logic [11:0] C_LBU  = 12'b0110_1101_1000;
    localparam logic [11:0] C_SW   = 12'b0011_0000_0000;
    localparam logic [11:0] C_BEQ  = 12'b0000_0010_0001;
    localparam logic [11:0] C_ADDI = 12'b0110_0000_0000;
    localparam logic [11:0] C_ANDI = 12'b0110_0000_0011;
    localparam logic [11:0] C_ORI  = 12'b0110_0000_0100;
    localparam logic [11:0] C_SLTI = 12'b0110_0000_0101;
    localparam logic [11:0] C_NONE = 12'b0000_0000_0000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic        wen;
        logic [31:0] dsel;
        logic [11:0] ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] ext;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] dbg;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                input logic [4:0] wreg, input logic [31:0] wdata,
                                input logic wen, input logic [31:0] dsel,
                                input logic [11:0] ctrl, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] ext,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [31:0] dbg);
        vec_t v;
        v.instr = instr; v.pc = pc; v.wreg = wreg; v.wdata = wdata; v.wen = wen;
        v.dsel = dsel; v.ctrl = ctrl; v.rd1 = rd1; v.rd2 = rd2; v.ext = ext;
        v.rt = rt; v.rd = rd; v.dbg = dbg;
        return v;
    endfunction

    function automatic logic [11:0] act_ctrl();
        return {RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, load_mode, ALUOp};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [4:0] wreg,
                         input logic [31:0] wdata, input logic wen, input logic [31:0] dsel);
        instruction     = instr;
        in_new_pc_value = pc;
        write_register  = wreg;
        write_data      = wdata;
        in_RegWrite     = wen;
        register_input  = dsel;
    endtask

    initial begin
        vecs[0]  = mk(32'h0000_0000, 32'h04, 5'd5,  32'hDEADBEEF, 1'b1, 32'd5,  C_R,    32'h0,        32'h0,  32'h0,        5'd0,  5'd0,  32'hDEADBEEF);
        vecs[1]  = mk(32'h00A6_2020, 32'h08, 5'd6,  32'h7,        1'b1, 32'd6,  C_R,    32'hDEADBEEF, 32'h7,  32'h2020,     5'd6,  5'd4,  32'h7);
        vecs[2]  = mk(32'h0000_2020, 32'h0C, 5'd0,  32'h1234,     1'b1, 32'd0,  C_R,    32'h0,        32'h0,  32'h2020,     5'd0,  5'd4,  32'h0);
        vecs[3]  = mk(32'h8CA7_0010, 32'h10, 5'd5,  32'h55,       1'b1, 32'd5,  C_LW,   32'h55,       32'h0,  32'h10,       5'd7,  5'd0,  32'h55);
        vecs[4]  = mk(32'h1085_FFFC, 32'h40, 5'd0,  32'h0,        1'b0, 32'd6,  C_BEQ,  32'h0,        32'h55, 32'hFFFFFFFC, 5'd5,  5'd31, 32'h7);
        vecs[5]  = mk(32'hFC00_0000, 32'h44, 5'd0,  32'h0,        1'b0, 32'd2,  C_NONE, 32'h0,        32'h0,  32'h0,        5'd0,  5'd0,  32'h0);
        vecs[6]  = mk(32'h84A8_8000, 32'h48, 5'd0,  32'h0,        1'b0, 32'd5,  C_LH,   32'h55,       32'h0,  32'hFFFF8000, 5'd8,  5'd16, 32'h55);
        vecs[7]  = mk(32'h80A9_0001, 32'h4C, 5'd0,  32'h0,        1'b0, 32'd0,  C_LB,   32'h55,       32'h0,  32'h1,        5'd9,  5'd0,  32'h0);
        vecs[8]  = mk(32'h90AA_0003, 32'h50, 5'd0,  32'h0,        1'b0, 32'd6,  C_LBU,  32'h55,       32'h0,  32'h3,        5'd10, 5'd0,  32'h7);
        vecs[9]  = mk(32'hACA6_0008, 32'h54, 5'd0,  32'h0,        1'b0, 32'd5,  C_SW,   32'h55,       32'h7,  32'h8,        5'd6,  5'd0,  32'h55);
        vecs[10] = mk(32'h20CB_7FFF, 32'h58, 5'd0,  32'h0,        1'b0, 32'd6,  C_ADDI, 32'h7,        32'h0,  32'h7FFF,     5'd11, 5'd15, 32'h7);
        vecs[11] = mk(32'h30A6_00FF, 32'h5C, 5'd0,  32'h0,        1'b0, 32'd5,  C_ANDI, 32'h55,       32'h7,  32'hFF,       5'd6,  5'd0,  32'h55);
        vecs[12] = mk(32'h34A6_0001, 32'h60, 5'd0,  32'h0,        1'b0, 32'd5,  C_ORI,  32'h55,       32'h7,  32'h1,        5'd6,  5'd0,  32'h55);
        vecs[13] = mk(32'h28A6_FFFF, 32'h64, 5'd0,  32'h0,        1'b0, 32'd5,  C_SLTI, 32'h55,       32'h7,  32'hFFFFFFFF, 5'd6,  5'd31, 32'h55);
        vecs[14] = mk(32'h03E0_0000, 32'h68, 5'd31, 32'hA5A5A5A5, 1'b1, 32'hFFFFFFFF, C_R, 32'hA5A5A5A5, 32'h0, 32'h0,     5'd0,  5'd0,  32'hA5A5A5A5);
        vecs[15] = mk(32'h0800_0000, 32'h6C, 5'd0,  32'h0,        1'b0, 32'd31, C_NONE, 32'h0,        32'h0,  32'h0,        5'd0,  5'd0,  32'hA5A5A5A5);

`ifdef ID_FLUSH_EN
        flush = 1'b0;
`endif
        // Reset held across several clock edges with busy inputs: everything must stay zero.
        rst_n = 1'b0;
        drive(32'h8CA7_0010, 32'h100, 5'd5, 32'h1111, 1'b0, 32'd5);
        #22;
        chk("reset_outputs", {4'h0, ALUOp, load_mode, RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
            MemToReg, Branch, instr_bits_15_11, instr_bits_20_16} | extended_bits | read_data1
            | read_data2 | new_pc_value, 32'h0);
        chk("reset_debug", debug_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].pc, vecs[i].wreg, vecs[i].wdata, vecs[i].wen, vecs[i].dsel);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ctrl", i), {20'h0, act_ctrl()}, {20'h0, vecs[i].ctrl});
            chk($sformatf("v%0d_rd1", i), read_data1, vecs[i].rd1);
            chk($sformatf("v%0d_rd2", i), read_data2, vecs[i].rd2);
            chk($sformatf("v%0d_ext", i), extended_bits, vecs[i].ext);
            chk($sformatf("v%0d_rt", i), {27'h0, instr_bits_20_16}, {27'h0, vecs[i].rt});
            chk($sformatf("v%0d_rd", i), {27'h0, instr_bits_15_11}, {27'h0, vecs[i].rd});
            chk($sformatf("v%0d_pc", i), new_pc_value, vecs[i].pc);
            chk($sformatf("v%0d_dbg", i), debug_data, vecs[i].dbg);
        end

        // Outputs must not move until the next rising edge.
        @(negedge clk);
        drive(32'h8CA7_0010, 32'h200, 5'd0, 32'h0, 1'b0, 32'd5);
        #1;
        chk("latency_pc_hold", new_pc_value, 32'h6C);
        chk("latency_ctrl_hold", {20'h0, act_ctrl()}, {20'h0, C_NONE});
        @(posedge clk);
        #1;
        chk("latency_pc_new", new_pc_value, 32'h200);
        chk("latency_ctrl_new", {20'h0, act_ctrl()}, {20'h0, C_LW});

`ifdef ID_FLUSH_EN
        @(negedge clk);
        drive(32'h8CA7_0010, 32'h204, 5'd6, 32'h99, 1'b1, 32'd6);
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_ctrl", {20'h0, act_ctrl()}, {20'h0, 12'b0010_0000_0000});
        chk("flush_ext", extended_bits, 32'h10);
        chk("flush_rd1", read_data1, 32'h55);
        @(negedge clk);
        flush = 1'b0;
        drive(32'h00A6_2020, 32'h208, 5'd0, 32'h0, 1'b0, 32'd6);
        @(posedge clk);
        #1;
        chk("flush_regwrite_kept", read_data2, 32'h99);
`endif

        // Asynchronous reset in the middle of the high phase.
        @(posedge clk);
        #2;
        in_RegWrite = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {4'h0, ALUOp, load_mode, RegDst, RegWrite, ALUSrc, MemWrite, MemRead,
            MemToReg, Branch, instr_bits_15_11, instr_bits_20_16} | extended_bits | read_data1
            | read_data2 | new_pc_value, 32'h0);
        register_input = 32'd5;
        #1;
        chk("midreset_debug5", debug_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h00A6_2020, 32'h300, 5'd0, 32'h0, 1'b0, 32'd31);
        @(posedge clk);
        #1;
        chk("postreset_rd1", read_data1, 32'h0);
        chk("postreset_rd2", read_data2, 32'h0);
        chk("postreset_ctrl", {20'h0, act_ctrl()}, {20'h0, C_R});
        chk("postreset_debug31", debug_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
- MIPS-style instruction-decode stage: control decoder, 32x32 register file and the ID/EX pipeline register combined in one block.
- Takes the IF/ID instruction and PC+4 plus the write-back port from WB.
- Produces registered operands, sign-extended immediate, destination fields and control signals for EX.
- Sits between the IF/ID register and the EX stage.

Parameters:
- none (fixed 32-bit datapath, 32 registers)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instruction  in  32  instruction from IF/ID
- in_new_pc_value  in  32  PC+4 from IF/ID
- write_register  in  5  WB destination register index
- write_data  in  32  WB data
- in_RegWrite  in  1  WB write enable
- register_input  in  32  debug read select; bits [4:0] used, [31:5] ignored
- debug_data  out  32  combinational contents of register register_input[4:0], including write bypass
- instr_bits_15_11  out  5  registered instruction[15:11] (rd)
- instr_bits_20_16  out  5  registered instruction[20:16] (rt)
- extended_bits  out  32  registered sign-extended instruction[15:0]
- read_data1  out  32  registered rs operand
- read_data2  out  32  registered rt operand
- new_pc_value  out  32  registered PC+4
- RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch  out  1 each  registered control
- load_mode  out  2  registered load width: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- ALUOp  out  3  registered ALU operation class

Behaviour:
- Reset:
  - Asynchronous, active-low reset on rst_n; all 32 registers and every ID/EX output clear to 0 while rst_n=0.
  - First capture occurs on the first clk rise after rst_n deasserts.
- Register file:
  - Two combinational read ports addressed by instruction[25:21] (rs) and instruction[20:16] (rt).
  - Write on rising clk when in_RegWrite=1 and write_register!=0.
  - $0 always reads 0; writes to $0 are ignored.
  - Write-through bypass: a read port whose address equals write_register (nonzero) while in_RegWrite=1 returns write_data in the same cycle. This applies to both read ports and to debug_data.
- Immediate: extended_bits = {16{instruction[15]}, instruction[15:0]}. Sign extension is used for all opcodes.
- Control decode (combinational on instruction[31:26]); signals not listed are 0; load_mode=00 unless stated:
  - 000000 R-type: RegDst=1, RegWrite=1, ALUOp=010
  - 100011 lw: ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1, ALUOp=000, load_mode=00
  - 100001 lh: as lw, load_mode=01
  - 100000 lb: as lw, load_mode=10
  - 100100 lbu: as lw, load_mode=11
  - 101011 sw: ALUSrc=1, MemWrite=1, ALUOp=000
  - 000100 beq: Branch=1, ALUOp=001
  - 001000 addi: ALUSrc=1, RegWrite=1, ALUOp=000
  - 001100 andi: ALUSrc=1, RegWrite=1, ALUOp=011
  - 001101 ori: ALUSrc=1, RegWrite=1, ALUOp=100
  - 001010 slti: ALUSrc=1, RegWrite=1, ALUOp=101
  - any other opcode: all control 0 (bubble); datapath fields still captured
- ID/EX register:
  - On every rising clk (rst_n=1), all decoded and datapath values are captured into the outputs.
  - Latency is one cycle from instruction to outputs; there is no stall input.
- Simultaneous write and read of the same register in one cycle: the captured operand is the new write_data (bypass).

Optional Feature:
- Macro ID_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 at a clk rise forces RegWrite, MemWrite, MemRead, MemToReg and Branch to 0 in the ID/EX register.
  - All other fields capture normally.
  - Register-file writes are unaffected by flush.
- When undefined: no flush port; behaviour exactly as above.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all outputs 0 immediately; register $5 reads 0 afterwards.
- Write $5: write_register=5, write_data=0xDEADBEEF, in_RegWrite=1, clk. Then issue instruction 0x00A62020 (add $4,$5,$6) -> next cycle read_data1=0xDEADBEEF, RegDst=1, RegWrite=1, ALUOp=010, instr_bits_15_11=4.
- $0 write: write_register=0, write_data=0x1234, in_RegWrite=1 -> debug_data for register_input=0 stays 0.
- Bypass: instruction 0x8CA70010 (lw $7,16($5)) in the same cycle as a write of 0x55 to $5 -> read_data1=0x55, extended_bits=0x10, MemRead=1, MemToReg=1, ALUSrc=1, load_mode=00.
- Sign extension and beq: instruction 0x1085FFFC -> extended_bits=0xFFFFFFFC, Branch=1, ALUOp=001, RegWrite=0; new_pc_value mirrors in_new_pc_value=0x40 one cycle later.
- Unknown opcode 0xFC000000 -> all control outputs 0. With ID_FLUSH_EN, flush=1 on an lw -> MemRead=0, RegWrite=0.
